req_encoder_8to3: RTL and testbench

- Sequential 8-to-3 request encoder; the inverse of the team's 3-to-8 decoder.
- Captures one-hot or multi-hot request lines into a pending register and emits the 3-bit index of one pending request at a time on a valid/ready handshake.
- Accepted indices are cleared from pending.
- Sits between scattered event/request sources and a consumer that wants binary codes, e.g. a decoder-driven select path or an event log.

---
 rtl/req_enc_pkg.sv | 20 ++
 rtl/req_encoder_8to3_prio_sel.sv | 36 +++
 rtl/req_encoder_8to3.sv | 127 ++++++++++++
 tb/tb_req_encoder_8to3.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared types and helpers for the sequential request encoder.
//   state_t   : encoder FSM states (IDLE, PRESENT).
//   N_DEFAULT : default number of request lines.
//   MAX_N     : widest request vector the one-hot helper supports.
//   onehot()  : index -> one-hot vector (callers size-cast down to N bits).
package req_enc_pkg;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned MAX_N     = 64;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/req_encoder_8to3_prio_sel.sv
// prio_sel: combinational find-first-set over an N-bit vector.
// The search starts at offset_i and wraps past N-1 back to 0. N is a
// power of two, so truncating the running position to CODE_W bits
// performs the wrap.
//   vec_i    [N-1:0]      : candidate bits
//   offset_i [CODE_W-1:0] : first index examined
//   idx_o    [CODE_W-1:0] : index of the first set bit found (0 if none)
//   found_o               : at least one bit of vec_i is set
module prio_sel
  import req_enc_pkg::*;
#(
  parameter int unsigned N      = N_DEFAULT,
  parameter int unsigned CODE_W = $clog2(N)
) (
  input  logic [N-1:0]      vec_i,
  input  logic [CODE_W-1:0] offset_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              found_o
);

  logic [CODE_W-1:0] pos;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = CODE_W'(32'(offset_i) + i);
      if (!found_o && vec_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: sequential N-to-log2(N) request encoder.
// Request lines are captured into a pending register. One pending index at
// a time is presented on a valid/ready handshake, and accepted indices are
// cleared from pending. When a bit is re-requested in the same cycle it is
// accepted, the set wins.
// Optional build macro REQ_ENC_ROUND_ROBIN_EN: round-robin selection that
// starts after the last accepted index. Default is fixed priority, with the
// lowest index winning.
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   en            : capture enable for req
//   req     [N]   : level-sampled request lines
//   code    [CW]  : registered index of the presented request
//   valid         : registered, code is valid
//   ready         : consumer accepts code when valid && ready
//   pending [N]   : pending-request register
//   dup           : one-cycle pulse, a captured bit was already pending
module req_encoder_8to3
  import req_enc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] code,
  output logic                 valid,
  input  logic                 ready,
  output logic [N-1:0]         pending,
  output logic                 dup
);

  localparam int unsigned CODE_W = $clog2(N);

  state_t            state_q;
  logic [N-1:0]      pending_q, pending_d;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              dup_q, dup_d;

  logic [N-1:0]      cap, clr;
  logic              accept;
  logic [CODE_W-1:0] sel_offset, sel_idx;
  logic              sel_found;

  assign accept = valid_q & ready;

  always_comb begin
    cap       = en ? req : '0;
    clr       = accept ? N'(onehot(32'(code_q))) : '0;
    pending_d = (pending_q & ~clr) | cap;
    dup_d     = |(cap & pending_q & ~clr);
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_q;

  // On an accept edge, last_accepted becomes code_q. The next selection
  // therefore starts from code_q+1 and does not use the stale register.
  assign sel_offset = accept ? code_q + 1'b1 : last_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= CODE_W'(N - 1);
    end else if (accept) begin
      last_q <= code_q;
    end
  end
`else
  assign sel_offset = '0;
`endif

  prio_sel #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_sel (
    .vec_i    (pending_d),
    .offset_i (sel_offset),
    .idx_o    (sel_idx),
    .found_o  (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dup_q     <= dup_d;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q <= PRESENT;
            code_q  <= sel_idx;
            valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          // The code is held under backpressure. It only moves on accept.
          if (accept) begin
            if (sel_found) begin
              code_q <= sel_idx;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign dup     = dup_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid, dup;
  logic [7:0] pending;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // reference state
  logic [7:0] m_pend;
  logic [2:0] m_code, m_last;
  logic       m_valid, m_dup;

  req_encoder_8to3 #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .dup     (dup)
  );

  always #5 clk = ~clk;

  // choose which pending request is presented next
  function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] last);
    int unsigned start;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    start = (int'(last) + 1) % 8;
`else
    start = 0;
    if (last == 3'd0) start = 0;
`endif
    for (int unsigned k = 0; k < 8; k++) begin
      int unsigned idx;
      idx = (start + k) % 8;
      if (p[idx]) return 3'(idx);
    end
    return 3'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance the reference by one clock edge using the inputs now applied
  task automatic model_edge();
    logic       acc;
    logic [7:0] cap, newp;
    if (rst) begin
      m_pend = 8'h00; m_code = 3'd0; m_valid = 1'b0; m_dup = 1'b0; m_last = 3'd7;
    end else begin
      acc  = m_valid && ready;
      cap  = en ? req : 8'h00;
      newp = m_pend;
      m_dup = 1'b0;
      for (int unsigned i = 0; i < 8; i++)
        if (cap[i] && m_pend[i] && !(acc && i == int'(m_code))) m_dup = 1'b1;
      if (acc) newp[m_code] = 1'b0;
      newp = newp | cap;
      if (acc) m_last = m_code;
      if (!m_valid || acc) begin
        if (newp != 8'h00) begin
          m_valid = 1'b1;
          m_code  = pick(newp, m_last);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = newp;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic rd);
    rst = r; en = e; req = q; ready = rd;
    model_edge();
    @(posedge clk);
    #1;
    check("valid",   32'(valid),   32'(m_valid));
    check("code",    32'(code),    32'(m_code));
    check("pending", 32'(pending), 32'(m_pend));
    check("dup",     32'(dup),     32'(m_dup));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 8'hFF; ready = 1'b0;
    m_pend = '0; m_code = '0; m_last = 3'd7; m_valid = 1'b0; m_dup = 1'b0;

    // reset overrides active inputs
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // single request
    step(1'b0, 1'b1, 8'h10, 1'b1);
    check("single_code", 32'(code), 32'd4);
    check("single_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("single_drained", 32'(pending), 32'd0);
    check("single_idle", 32'(valid), 32'd0);

    // backpressure holds code
    step(1'b0, 1'b1, 8'h80, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    check("bp_hold", 32'(code), 32'd7);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("bp_next", 32'(code), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // drain all eight from reset
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("drain_0", 32'(code), 32'd0);
    for (int unsigned i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("drain_seq", 32'(code), 32'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_done", 32'(valid), 32'd0);

    // set wins on accept cycle
    step(1'b0, 1'b1, 8'h08, 1'b0);
    step(1'b0, 1'b1, 8'h08, 1'b1);
    check("setwin_pend", 32'(pending), 32'h08);
    check("setwin_dup", 32'(dup), 32'd0);
    check("setwin_code", 32'(code), 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // duplicate on unaccepted pending bit
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    check("dup_pulse", 32'(dup), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("dup_clear", 32'(dup), 32'd0);

    // en gating, pending still drains
    step(1'b0, 1'b0, 8'hFF, 1'b0);
    check("en_gate", 32'(pending), 32'h20);
    step(1'b0, 1'b0, 8'hFF, 1'b1);
    check("en_drain", 32'(pending), 32'd0);

    // reset mid-handshake
    step(1'b0, 1'b1, 8'h06, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_pend", 32'(pending), 32'd0);

    // randomized traffic
    for (int unsigned n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255) & $urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
